// File: rtl/alu_cmd_sequencer_pkg.sv
// ============================================================================
// alu_cmd_sequencer_pkg : op codes, FSM states and defaults for the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_cmd_sequencer_pkg;

  localparam int DEF_WIDTH = 20;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // NOP and a faulted divide leave the register file untouched
  function automatic logic writes_back(input logic [2:0] op, input logic div_zero);
    return (op != OP_NOP) && !div_zero;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_cmd_sequencer_if.sv
// ============================================================================
// alu_cmd_sequencer_if : command, preload, response and ALU-side signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_cmd_sequencer_if
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AW-1:0]    cmd_rd;
  logic [AW-1:0]    cmd_rs1;
  logic [AW-1:0]    cmd_rs2;
  logic             wr_en;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_c;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
    output wr_en, wr_addr, wr_data, rsp_ready, alu_c,
    input  cmd_ready, wr_ready, alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_data, rsp_zero, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
    input  wr_en, wr_addr, wr_data, rsp_ready, alu_c,
    output cmd_ready, wr_ready, alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_data, rsp_zero, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/alu_regfile.sv
// ============================================================================
// alu_regfile : NREGS x WIDTH registers, two async read ports, one write port
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_regfile #(
  parameter int WIDTH = 20,
  parameter int NREGS = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata2
);
  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
endmodule

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// alu_cmd_sequencer : issues register-file operands to an external ALU and
// returns its result with zero / divide-by-zero status. Rev 1.0
// ============================================================================
`default_nettype none

module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = 4,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_sequencer_if.slave   bus
);
  state_t           state, state_nx;
  logic [AW-1:0]    rd_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [2:0]       alu_sel_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_zero_q, rsp_err_q;
  logic [WIDTH-1:0] rdata1, rdata2, opa, opb;
  logic             rf_we, accept, div_zero;
  logic [AW-1:0]    rf_waddr;
  logic [WIDTH-1:0] rf_wdata;

  alu_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr1 (bus.cmd_rs1),
    .rdata1 (rdata1),
    .raddr2 (bus.cmd_rs2),
    .rdata2 (rdata2)
  );

  // A preload landing in the same cycle as the accept is forwarded to the operands
  assign opa = (bus.wr_en && bus.wr_addr == bus.cmd_rs1) ? bus.wr_data : rdata1;
  assign opb = (bus.wr_en && bus.wr_addr == bus.cmd_rs2) ? bus.wr_data : rdata2;
  assign div_zero = (op_q == OP_DIV) && (alu_b_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Write port goes to preload in IDLE and to writeback on the ISSUE exit edge
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = bus.wr_addr;
    rf_wdata = bus.wr_data;
    case (state)
      ST_IDLE: begin
        rf_we = bus.wr_en;
        if (bus.cmd_valid) begin
          accept   = 1'b1;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rf_we    = writes_back(op_q, div_zero);
        rf_waddr = rd_q;
        rf_wdata = bus.alu_c;
        state_nx = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      op_q       <= OP_NOP;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= OP_NOP;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        alu_a_q   <= opa;
        alu_b_q   <= opb;
        alu_sel_q <= bus.cmd_op;
        rd_q      <= bus.cmd_rd;
        op_q      <= bus.cmd_op;
      end
      if (state == ST_ISSUE) begin
        if (op_q == OP_NOP) begin
          rsp_data_q <= '0;
          rsp_zero_q <= 1'b1;
          rsp_err_q  <= 1'b0;
        end else if (div_zero) begin
          rsp_data_q <= '1;
          rsp_zero_q <= 1'b0;
          rsp_err_q  <= 1'b1;
        end else begin
          rsp_data_q <= bus.alu_c;
          rsp_zero_q <= (bus.alu_c == '0);
          rsp_err_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.wr_ready  = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// tb_alu_cmd_sequencer : directed self-checking bench with a behavioural ALU
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;
  import alu_cmd_sequencer_pkg::*;

  localparam int W = 20;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_cmd_sequencer_if #(.WIDTH(W), .AW(2)) bus ();

  alu_cmd_sequencer #(.WIDTH(W), .NREGS(4), .AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference ALU; its divide-by-zero value is irrelevant since the sequencer overrides it
  always_comb begin
    bus.alu_c = '0;
    case (bus.alu_sel)
      OP_ADD:  bus.alu_c = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_c = bus.alu_a - bus.alu_b;
      OP_MUL:  bus.alu_c = bus.alu_a * bus.alu_b;
      OP_DIV:  bus.alu_c = (bus.alu_b == '0) ? '0 : bus.alu_a / bus.alu_b;
      OP_AND:  bus.alu_c = bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_c = bus.alu_a | bus.alu_b;
      OP_XOR:  bus.alu_c = bus.alu_a ^ bus.alu_b;
      default: bus.alu_c = '0;
    endcase
  end

  task automatic preload(input logic [1:0] addr, input logic [W-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [1:0] rd, rs1, rs2);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic v, output logic [W-1:0] d, output logic z, e);
    for (int i = 0; i < 8 && !bus.rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    v = bus.rsp_valid;
    d = bus.rsp_data;
    z = bus.rsp_zero;
    e = bus.rsp_err;
    if (v) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [1:0] rd, rs1, rs2,
                         output logic v, output logic [W-1:0] d, output logic z, e);
    send_cmd(op, rd, rs1, rs2);
    get_rsp(v, d, z, e);
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({bus.cmd_ready, bus.wr_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_err}
        !== {1'b1, 1'b1, 1'b0, 20'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_ctl: got rdy=%b wrdy=%b v=%b d=%h z=%b e=%b want 1 1 0 00000 0 0",
               bus.cmd_ready, bus.wr_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_err);
    end
    n_cmp++;
    if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== {20'h0, 20'h0, 3'b000}) begin
      n_err++;
      $display("FAIL reset_alu: got a=%h b=%h sel=%b want 0 0 000", bus.alu_a, bus.alu_b, bus.alu_sel);
    end
  endtask

  task automatic test_add;
    logic v, z, e;
    logic [W-1:0] d;
    preload(2'd0, 20'd5);
    preload(2'd1, 20'd3);
    send_cmd(OP_ADD, 2'd2, 2'd0, 2'd1);
    n_cmp++;
    if ({bus.alu_sel, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.cmd_ready}
        !== {OP_ADD, 20'd5, 20'd3, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL add_issue: got sel=%b a=%h b=%h v=%b rdy=%b want 001 5 3 0 0",
               bus.alu_sel, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.cmd_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_err} !== {1'b1, 20'd8, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL add_rsp: got v=%b d=%h z=%b e=%b want 1 00008 0 0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_err);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL add_done: got v=%b rdy=%b want 0 1", bus.rsp_valid, bus.cmd_ready);
    end
    run_cmd(OP_OR, 2'd3, 2'd2, 2'd2, v, d, z, e);
    n_cmp++;
    if ({v, d, z, e} !== {1'b1, 20'd8, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL add_wb: got v=%b d=%h z=%b e=%b want 1 00008 0 0", v, d, z, e);
    end
  endtask

  task automatic test_sub;
    logic v, z, e;
    logic [W-1:0] d;
    preload(2'd0, 20'd3);
    preload(2'd1, 20'd5);
    run_cmd(OP_SUB, 2'd2, 2'd0, 2'd1, v, d, z, e);
    n_cmp++;
    if ({v, d, z, e} !== {1'b1, 20'hFFFFE, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL sub_wrap: got v=%b d=%h z=%b e=%b want 1 ffffe 0 0", v, d, z, e);
    end
    run_cmd(OP_SUB, 2'd2, 2'd0, 2'd0, v, d, z, e);
    n_cmp++;
    if ({v, d, z, e} !== {1'b1, 20'h0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL sub_zero: got v=%b d=%h z=%b e=%b want 1 00000 1 0", v, d, z, e);
    end
  endtask

  task automatic test_mul;
    logic v, z, e;
    logic [W-1:0] d;
    preload(2'd0, 20'h00400);
    preload(2'd1, 20'h00400);
    run_cmd(OP_MUL, 2'd2, 2'd0, 2'd1, v, d, z, e);
    n_cmp++;
    if ({v, d, z, e} !== {1'b1, 20'h0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL mul_trunc: got v=%b d=%h z=%b e=%b want 1 00000 1 0", v, d, z, e);
    end
  endtask

  task automatic test_div_nop;
    logic v, z, e;
    logic [W-1:0] d;
    preload(2'd0, 20'd7);
    preload(2'd1, 20'd0);
    preload(2'd3, 20'h12345);
    run_cmd(OP_DIV, 2'd3, 2'd0, 2'd1, v, d, z, e);
    n_cmp++;
    if ({v, d, z, e} !== {1'b1, 20'hFFFFF, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL div_zero: got v=%b d=%h z=%b e=%b want 1 fffff 0 1", v, d, z, e);
    end
    run_cmd(OP_OR, 2'd2, 2'd3, 2'd3, v, d, z, e);
    n_cmp++;
    if (d !== 20'h12345) begin
      n_err++;
      $display("FAIL div_no_wb: got r3=%h want 12345", d);
    end
    run_cmd(OP_NOP, 2'd0, 2'd1, 2'd1, v, d, z, e);
    n_cmp++;
    if ({v, d, z, e} !== {1'b1, 20'h0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL nop_rsp: got v=%b d=%h z=%b e=%b want 1 00000 1 0", v, d, z, e);
    end
    run_cmd(OP_OR, 2'd2, 2'd0, 2'd0, v, d, z, e);
    n_cmp++;
    if (d !== 20'd7) begin
      n_err++;
      $display("FAIL nop_no_wb: got r0=%h want 00007", d);
    end
    preload(2'd1, 20'd2);
    run_cmd(OP_DIV, 2'd2, 2'd0, 2'd1, v, d, z, e);
    n_cmp++;
    if ({v, d, z, e} !== {1'b1, 20'd3, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL div_norm: got v=%b d=%h z=%b e=%b want 1 00003 0 0", v, d, z, e);
    end
  endtask

  task automatic test_backpressure;
    logic v, z, e;
    logic [W-1:0] d;
    preload(2'd0, 20'd1);
    preload(2'd1, 20'd2);
    bus.rsp_ready = 1'b0;
    send_cmd(OP_ADD, 2'd2, 2'd0, 2'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 2'd0;
      bus.wr_data = 20'hAAAAA;
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_data, bus.cmd_ready, bus.wr_ready} !== {1'b1, 20'd3, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h rdy=%b wrdy=%b want 1 00003 0 0",
                 i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready, bus.wr_ready);
      end
      @(posedge clk); #1;
    end
    bus.wr_en     = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_data, bus.cmd_ready} !== {1'b0, 20'd3, 1'b1}) begin
      n_err++;
      $display("FAIL bp_release: got v=%b d=%h rdy=%b want 0 00003 1",
               bus.rsp_valid, bus.rsp_data, bus.cmd_ready);
    end
    run_cmd(OP_OR, 2'd3, 2'd0, 2'd0, v, d, z, e);
    n_cmp++;
    if (d !== 20'd1) begin
      n_err++;
      $display("FAIL bp_wr_ignored: got r0=%h want 00001", d);
    end
  endtask

  task automatic test_forward;
    logic v, z, e;
    logic [W-1:0] d;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'd1;
    bus.wr_data = 20'd9;
    send_cmd(OP_ADD, 2'd2, 2'd1, 2'd0);
    bus.wr_en   = 1'b0;
    n_cmp++;
    if ({bus.alu_a, bus.alu_b} !== {20'd9, 20'd1}) begin
      n_err++;
      $display("FAIL fwd_operand: got a=%h b=%h want 00009 00001", bus.alu_a, bus.alu_b);
    end
    get_rsp(v, d, z, e);
    n_cmp++;
    if ({v, d} !== {1'b1, 20'd10}) begin
      n_err++;
      $display("FAIL fwd_rsp: got v=%b d=%h want 1 0000a", v, d);
    end
    run_cmd(OP_OR, 2'd3, 2'd1, 2'd1, v, d, z, e);
    n_cmp++;
    if (d !== 20'd9) begin
      n_err++;
      $display("FAIL fwd_written: got r1=%h want 00009", d);
    end
  endtask

  task automatic test_rd_eq_rs;
    logic v, z, e;
    logic [W-1:0] d;
    run_cmd(OP_ADD, 2'd0, 2'd0, 2'd0, v, d, z, e);
    n_cmp++;
    if (d !== 20'd2) begin
      n_err++;
      $display("FAIL rd_eq_rs: got d=%h want 00002", d);
    end
    run_cmd(OP_OR, 2'd3, 2'd0, 2'd0, v, d, z, e);
    n_cmp++;
    if (d !== 20'd2) begin
      n_err++;
      $display("FAIL rd_eq_rs_wb: got r0=%h want 00002", d);
    end
  endtask

  task automatic test_reset_midflight;
    logic v, z, e;
    logic [W-1:0] d;
    logic seen;
    preload(2'd0, 20'd4);
    preload(2'd1, 20'd4);
    send_cmd(OP_ADD, 2'd2, 2'd0, 2'd1);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.alu_a, bus.alu_b, bus.alu_sel, bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_err}
        !== {20'h0, 20'h0, 3'b000, 1'b0, 20'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_async: got a=%h b=%h sel=%b v=%b d=%h z=%b e=%b want all 0",
               bus.alu_a, bus.alu_b, bus.alu_sel, bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_err);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL rst_no_rsp: got rsp_valid seen=%b want 0", seen);
    end
    run_cmd(OP_OR, 2'd0, 2'd0, 2'd1, v, d, z, e);
    n_cmp++;
    if ({v, d, z} !== {1'b1, 20'h0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_regs01: got v=%b d=%h z=%b want 1 00000 1", v, d, z);
    end
    run_cmd(OP_OR, 2'd2, 2'd2, 2'd3, v, d, z, e);
    n_cmp++;
    if ({v, d, z} !== {1'b1, 20'h0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_regs23: got v=%b d=%h z=%b want 1 00000 1", v, d, z);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_rd    = '0;
    bus.cmd_rs1   = '0;
    bus.cmd_rs2   = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rsp_ready = 1'b1;
    #3;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_add();
    test_sub();
    test_mul();
    test_div_nop();
    test_backpressure();
    test_forward();
    test_rd_eq_rs();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000 want finished");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-side driver for the 20-bit combinational ALU: accepts operation commands over a valid/ready interface and reads operands from a small local register file.
- Drives the ALU's a/b/sel inputs, captures its result c, and writes the result back to the register file.
- Returns data, zero and error status over a valid/ready response interface.
- Sits between the control/test logic and the ALU instance. The ALU's own zero output is not used; zero is computed locally from alu_c.

Parameters:
- WIDTH, 20, operand/result width; must match ALU.
- NREGS, 4, register file depth.
- AW, 2, register address width (log2 NREGS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  3  001 add, 010 sub, 011 mul, 100 div, 101 and, 110 or, 111 xor, 000 NOP.
- cmd_rd  in  AW  destination register.
- cmd_rs1  in  AW  source for ALU a.
- cmd_rs2  in  AW  source for ALU b.
- wr_en  in  1  preload strobe.
- wr_ready  out  1  high only in IDLE.
- wr_addr  in  AW  preload address.
- wr_data  in  WIDTH  preload data.
- alu_a  out  WIDTH  registered operand a to ALU.
- alu_b  out  WIDTH  registered operand b to ALU.
- alu_sel  out  3  registered op select to ALU.
- alu_c  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_sel).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  WIDTH  result.
- rsp_zero  out  1  rsp_data == 0.
- rsp_err  out  1  divide by zero.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all registers=0; alu_a/alu_b/alu_sel=0; rsp_valid/rsp_data/rsp_zero/rsp_err=0. Any in-flight command is dropped with no response.
- FSM has three states: IDLE, ISSUE, RESP.
- IDLE:
  - cmd_ready=1, wr_ready=1.
  - wr_en writes reg[wr_addr] at the edge.
  - On cmd_valid: alu_a<=reg[rs1], alu_b<=reg[rs2], alu_sel<=cmd_op, latch rd/op; go to ISSUE.
- Simultaneous preload and command in IDLE: the preload write happens, and any rs equal to wr_addr forwards wr_data; the command sees the new value.
- ISSUE: one cycle for the ALU to settle. At the exit edge, set rsp_* and go to RESP:
  - Normal op: rsp_data<=alu_c, rsp_zero<=(alu_c==0), rsp_err<=0, reg[rd]<=alu_c.
  - DIV with alu_b==0: rsp_data<=all ones, rsp_zero<=0, rsp_err<=1, no writeback.
  - NOP: rsp_data<=0, rsp_zero<=1, rsp_err<=0, no writeback.
- RESP:
  - rsp_valid=1; rsp_* held stable while rsp_ready=0.
  - On rsp_ready: go to IDLE, rsp_valid=0 the next cycle.
  - rsp_data/zero/err hold their last values until the next response.
- Latency: alu_* valid 1 cycle after accept; rsp_valid 2 cycles after accept. Minimum 3 cycles per command with rsp_ready tied high.
- Arithmetic: all results are the low WIDTH bits from the ALU, so sub and add wrap modulo 2^WIDTH and mul is truncated. The sequencer does no arithmetic of its own beyond the zero and divide-by-zero checks.
- wr_en outside IDLE is ignored; wr_ready=0 there.
- rd equal to rs1 or rs2 is legal: operands are read at accept, writeback happens later.

Decomposition:
- Shared header alu_defs.vh holds:
  - op code localparams (OP_NOP..OP_XOR), shared with the ALU and the bench;
  - FSM state encodings;
  - WIDTH default.
- One sub-module, alu_regfile: NREGS x WIDTH, two combinational read ports, one write port, async reset to 0. The sequencer arbitrates its single write port between preload (IDLE) and writeback (ISSUE exit); the two are never concurrent by construction.
- ALU is instantiated by the bench/top, not inside the sequencer.

Test Plan:
- Preload r0=5, r1=3; cmd ADD rd=2 rs1=0 rs2=1 -> one cycle later alu_sel=001, a=5, b=3; two cycles later rsp_valid=1, rsp_data=8, zero=0, err=0; a follow-up cmd reading r2 sees 8.
- Preload r0=3, r1=5; SUB r0-r1 -> rsp_data=0xFFFFE, zero=0. SUB r0-r0 -> rsp_data=0, zero=1.
- Preload r0=r1=0x00400; MUL -> rsp_data=0x00000 (truncated 0x100000), zero=1.
- Preload r0=7, r1=0, r3=0x12345; DIV rd=3 rs1=0 rs2=1 -> err=1, rsp_data=0xFFFFF, r3 still 0x12345.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable; cmd_ready=0 and wr_en ignored throughout. Same-cycle wr_en(r1=9) with cmd ADD rs1=r1 -> alu_a=9.
- Assert rst_n low during ISSUE -> all outputs 0 immediately; no response appears after release; all registers read 0.
